// File: rtl/bsg_gateway_tag_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsg_gateway_tag_rx : serial tag packet decoder with a single-entry buffer
// Revision 1.0
// ---------------------------------------------------------------------------
module bsg_gateway_tag_rx #(
  parameter int node_id_width_p = 5,
  parameter int len_width_p     = 5,
  parameter int payload_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tag_tdi_i,
  input  logic                       tag_tms_i,
  output logic                       valid_o,
  input  logic                       yumi_i,
  output logic [node_id_width_p-1:0] node_id_o,
  output logic                       data_not_reset_o,
  output logic [len_width_p-1:0]     len_o,
  output logic [payload_width_p-1:0] data_o,
  output logic                       overflow_o,
  output logic                       len_err_o
);

  localparam int c_id_cnt_w = (node_id_width_p > 1) ? $clog2(node_id_width_p) : 1;
  localparam int c_cnt_w    = (len_width_p > c_id_cnt_w) ? len_width_p : c_id_cnt_w;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_id_last  = c_cnt_w'(node_id_width_p - 1);
  localparam logic [c_cnt_w-1:0] c_len_last = c_cnt_w'(len_width_p - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID      = 3'd1,
    S_DNR     = 3'd2,
    S_LEN     = 3'd3,
    S_PAYLOAD = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [c_cnt_w-1:0]         cnt_q, cnt_d;
  logic [node_id_width_p-1:0] node_id_q, node_id_d;
  logic                       dnr_q, dnr_d;
  logic [len_width_p-1:0]     len_q, len_d;
  logic [payload_width_p-1:0] data_q, data_d;

  logic                       valid_q, valid_d;
  logic [node_id_width_p-1:0] out_id_q, out_id_d;
  logic                       out_dnr_q, out_dnr_d;
  logic [len_width_p-1:0]     out_len_q, out_len_d;
  logic [payload_width_p-1:0] out_data_q, out_data_d;
  logic                       overflow_q, overflow_d;
  logic                       len_err_q, len_err_d;

  logic                       w_done;
  logic                       w_len_err_set;
  logic [len_width_p-1:0]     w_pkt_len;
  logic [payload_width_p-1:0] w_pkt_data;
  logic [node_id_width_p-1:0] w_id_next;
  logic [len_width_p-1:0]     w_len_next;
  logic [payload_width_p-1:0] w_data_next;
  logic                       w_len_next_big;
  logic                       w_len_q_big;

  // Fields arrive LSB first, so each new bit enters at the top and shifts down.
  assign w_id_next      = (node_id_q >> 1) | (node_id_width_p'(tag_tdi_i) << (node_id_width_p - 1));
  assign w_len_next     = (len_q >> 1) | (len_width_p'(tag_tdi_i) << (len_width_p - 1));
  assign w_data_next    = data_q | (payload_width_p'(tag_tdi_i) << cnt_q);
  assign w_len_next_big = 32'(w_len_next) > payload_width_p;
  assign w_len_q_big    = 32'(len_q) > payload_width_p;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    node_id_d     = node_id_q;
    dnr_d         = dnr_q;
    len_d         = len_q;
    data_d        = data_q;
    w_done        = 1'b0;
    w_len_err_set = 1'b0;
    w_pkt_len     = len_q;
    w_pkt_data    = data_q;

    if (tag_tms_i) begin
      case (state_q)
        S_IDLE: begin
          if (tag_tdi_i) begin
            state_d = S_ID;
            cnt_d   = '0;
            data_d  = '0;
          end
        end
        S_ID: begin
          node_id_d = w_id_next;
          if (cnt_q == c_id_last) begin
            state_d = S_DNR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        S_DNR: begin
          dnr_d   = tag_tdi_i;
          state_d = S_LEN;
          cnt_d   = '0;
        end
        S_LEN: begin
          len_d     = w_len_next;
          w_pkt_len = w_len_next;
          if (cnt_q == c_len_last) begin
            cnt_d = '0;
            if (w_len_next == '0) begin
              state_d = S_IDLE;
              w_done  = 1'b1;
            end else begin
              // Oversized packets still walk PAYLOAD to skip their bits.
              state_d       = S_PAYLOAD;
              w_len_err_set = w_len_next_big;
            end
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        S_PAYLOAD: begin
          if (!w_len_q_big) begin
            data_d     = w_data_next;
            w_pkt_data = w_data_next;
          end
          if ((cnt_q + c_cnt_one) == c_cnt_w'(len_q)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            w_done  = !w_len_q_big;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    valid_d    = valid_q;
    out_id_d   = out_id_q;
    out_dnr_d  = out_dnr_q;
    out_len_d  = out_len_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;
    len_err_d  = len_err_q | w_len_err_set;

    if (w_done) begin
      // A consume in the completion cycle frees the slot for the new packet.
      if (!valid_q || yumi_i) begin
        valid_d    = 1'b1;
        out_id_d   = node_id_q;
        out_dnr_d  = dnr_q;
        out_len_d  = w_pkt_len;
        out_data_d = w_pkt_data;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && yumi_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      node_id_q  <= '0;
      dnr_q      <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      out_id_q   <= '0;
      out_dnr_q  <= 1'b0;
      out_len_q  <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      node_id_q  <= node_id_d;
      dnr_q      <= dnr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      out_id_q   <= out_id_d;
      out_dnr_q  <= out_dnr_d;
      out_len_q  <= out_len_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      len_err_q  <= len_err_d;
    end
  end

  assign valid_o          = valid_q;
  assign node_id_o        = out_id_q;
  assign data_not_reset_o = out_dnr_q;
  assign len_o            = out_len_q;
  assign data_o           = out_data_q;
  assign overflow_o       = overflow_q;
  assign len_err_o        = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_gateway_tag_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bsg_gateway_tag_rx : vector table, corner sequences and random traffic
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_bsg_gateway_tag_rx;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        tdi, tms, yumi;
  logic        valid_o, dnr_o, ovf_o, lerr_o;
  logic [4:0]  id_o, len_o;
  logic [15:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bsg_gateway_tag_rx #(
    .node_id_width_p(5),
    .len_width_p    (5),
    .payload_width_p(16)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .tag_tdi_i       (tdi),
    .tag_tms_i       (tms),
    .valid_o         (valid_o),
    .yumi_i          (yumi),
    .node_id_o       (id_o),
    .data_not_reset_o(dnr_o),
    .len_o           (len_o),
    .data_o          (data_o),
    .overflow_o      (ovf_o),
    .len_err_o       (lerr_o)
  );

  typedef struct {
    logic [4:0]  id;
    logic        dnr;
    int          len;
    logic [31:0] data;
    int          gap;
    logic        ev;
    logic [4:0]  eid;
    logic        edn;
    logic [4:0]  elen;
    logic [15:0] edata;
    logic        elerr;
  } vec_t;

  typedef struct {
    logic        b;
    logic        last;
    logic        errmark;
    logic [4:0]  id;
    logic        dnr;
    logic [4:0]  len;
    logic [15:0] data;
  } sbit_t;

  vec_t  tbl [6];
  sbit_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1; tms = 1'b0; tdi = 1'b0; yumi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int maxgap, input logic yumi_with);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    for (int i = 0; i < g; i++) begin
      tms = 1'b0; tdi = 1'($urandom); yumi = 1'b0;
      @(negedge clk);
    end
    tms = 1'b1; tdi = b; yumi = yumi_with;
    @(negedge clk);
    tms = 1'b0; yumi = 1'b0;
  endtask

  task automatic send_pkt(input logic [4:0] id, input logic dnr, input int len,
                          input logic [31:0] data, input int maxgap, input logic yumi_last);
    logic [4:0] lv;
    lv = len[4:0];
    send_bit(1'b1, maxgap, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(id[k], maxgap, 1'b0);
    send_bit(dnr, maxgap, (len == 0) ? 1'b0 : 1'b0);
    for (int k = 0; k < 5; k++) send_bit(lv[k], maxgap, (len == 0 && k == 4) ? yumi_last : 1'b0);
    for (int k = 0; k < len; k++) send_bit(data[k], maxgap, (k == len - 1) ? yumi_last : 1'b0);
  endtask

  task automatic check_pkt(input string tag, input logic [4:0] eid, input logic edn,
                           input logic [4:0] elen, input logic [15:0] edata);
    chk({tag, " valid"}, 32'(valid_o), 32'd1);
    chk({tag, " node_id"}, 32'(id_o), 32'(eid));
    chk({tag, " dnr"}, 32'(dnr_o), 32'(edn));
    chk({tag, " len"}, 32'(len_o), 32'(elen));
    chk({tag, " data"}, 32'(data_o), 32'(edata));
  endtask

  task automatic push_random_pkt();
    sbit_t e;
    int    len;
    logic [31:0] d;
    logic [4:0]  id;
    logic        dnr;
    logic [4:0]  lv;
    int idle;
    idle = int'($urandom_range(2, 0));
    e = '{b: 1'b0, last: 1'b0, errmark: 1'b0, id: 5'd0, dnr: 1'b0, len: 5'd0, data: 16'd0};
    for (int i = 0; i < idle; i++) q.push_back(e);
    id  = 5'($urandom);
    dnr = 1'($urandom);
    len = ($urandom_range(9, 0) == 0) ? int'($urandom_range(31, 17)) : int'($urandom_range(16, 0));
    d   = (len > 16) ? $urandom : ($urandom & ((32'd1 << len) - 32'd1));
    lv  = len[4:0];
    e.id = id; e.dnr = dnr; e.len = lv; e.data = d[15:0];
    e.b = 1'b1; q.push_back(e);
    for (int k = 0; k < 5; k++) begin e.b = id[k]; q.push_back(e); end
    e.b = dnr; q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      e.b       = lv[k];
      e.last    = (k == 4) && (len == 0);
      e.errmark = (k == 4) && (len > 16);
      q.push_back(e);
    end
    e.errmark = 1'b0;
    for (int k = 0; k < len; k++) begin
      e.b    = d[k];
      e.last = (k == len - 1) && (len <= 16);
      q.push_back(e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_valid, m_ovf, m_lerr;
    sbit_t       m_pkt, e;
    logic        load_evt;
    int          guard;

    tbl[0] = '{5'd3,  1'b1, 4,  32'h000D, 0, 1'b1, 5'd3,  1'b1, 5'd4,  16'h000D, 1'b0};
    tbl[1] = '{5'd3,  1'b1, 4,  32'h000D, 3, 1'b1, 5'd3,  1'b1, 5'd4,  16'h000D, 1'b0};
    tbl[2] = '{5'd7,  1'b0, 0,  32'h0000, 0, 1'b1, 5'd7,  1'b0, 5'd0,  16'h0000, 1'b0};
    tbl[3] = '{5'd31, 1'b1, 16, 32'hA5C3, 1, 1'b1, 5'd31, 1'b1, 5'd16, 16'hA5C3, 1'b0};
    tbl[4] = '{5'd0,  1'b1, 1,  32'h0001, 2, 1'b1, 5'd0,  1'b1, 5'd1,  16'h0001, 1'b0};
    tbl[5] = '{5'd5,  1'b1, 17, 32'h1FFFF, 0, 1'b0, 5'd0, 1'b0, 5'd0,  16'h0000, 1'b1};

    reset_i = 1'b1; tms = 1'b0; tdi = 1'b0; yumi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", {2'b0, valid_o, id_o, dnr_o, len_o, data_o, ovf_o, lerr_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_pkt(tbl[i].id, tbl[i].dnr, tbl[i].len, tbl[i].data, tbl[i].gap, 1'b0);
      chk($sformatf("vec%0d valid", i), 32'(valid_o), 32'(tbl[i].ev));
      chk($sformatf("vec%0d len_err", i), 32'(lerr_o), 32'(tbl[i].elerr));
      chk($sformatf("vec%0d overflow", i), 32'(ovf_o), 32'd0);
      if (tbl[i].ev) begin
        check_pkt($sformatf("vec%0d", i), tbl[i].eid, tbl[i].edn, tbl[i].elen, tbl[i].edata);
        yumi = 1'b1;
        @(negedge clk);
        yumi = 1'b0;
        chk($sformatf("vec%0d valid after yumi", i), 32'(valid_o), 32'd0);
      end
    end

    // Back-to-back with no consume: first packet kept, overflow raised.
    do_reset();
    send_pkt(5'd3, 1'b1, 4, 32'hD, 0, 1'b0);
    send_pkt(5'd9, 1'b0, 2, 32'h2, 0, 1'b0);
    check_pkt("ovf keep", 5'd3, 1'b1, 5'd4, 16'h000D);
    chk("ovf flag set", 32'(ovf_o), 32'd1);

    // Consume coincident with completion: new packet replaces old, no overflow.
    do_reset();
    send_pkt(5'd3, 1'b1, 4, 32'hD, 0, 1'b0);
    send_pkt(5'd9, 1'b0, 2, 32'h2, 0, 1'b1);
    check_pkt("yumi swap", 5'd9, 1'b0, 5'd2, 16'h0002);
    chk("yumi swap ovf", 32'(ovf_o), 32'd0);

    // Oversized length is skipped and the following packet still decodes.
    do_reset();
    send_pkt(5'd1, 1'b1, 20, $urandom, 0, 1'b0);
    chk("lenerr flag", 32'(lerr_o), 32'd1);
    chk("lenerr no valid", 32'(valid_o), 32'd0);
    send_pkt(5'd6, 1'b1, 3, 32'h5, 1, 1'b0);
    check_pkt("after lenerr", 5'd6, 1'b1, 5'd3, 16'h0005);
    chk("lenerr sticky", 32'(lerr_o), 32'd1);

    // Reset pulse in the middle of a payload.
    do_reset();
    send_pkt(5'd2, 1'b1, 1, 32'h1, 0, 1'b0);
    chk("pre-reset valid", 32'(valid_o), 32'd1);
    send_bit(1'b1, 0, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(k == 3, 0, 1'b0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 0, 1'b0);
    reset_i = 1'b1;
    #1;
    chk("midreset outputs", {2'b0, valid_o, id_o, dnr_o, len_o, data_o, ovf_o, lerr_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) send_bit(1'b0, 0, 1'b0);
    chk("post-reset idle", 32'(valid_o), 32'd0);
    send_pkt(5'd10, 1'b1, 5, 32'h13, 1, 1'b0);
    check_pkt("post-reset pkt", 5'd10, 1'b1, 5'd5, 16'h0013);

    // Random traffic against a transaction-level model of the output slot.
    do_reset();
    for (int p = 0; p < 40; p++) push_random_pkt();
    m_valid = 1'b0; m_ovf = 1'b0; m_lerr = 1'b0;
    m_pkt = '{b: 1'b0, last: 1'b0, errmark: 1'b0, id: 5'd0, dnr: 1'b0, len: 5'd0, data: 16'd0};
    guard = 0;
    while ((q.size() > 0 || guard < 5) && guard < 20000) begin
      if (q.size() == 0) guard++;
      else guard = (guard > 0) ? guard : 0;
      chk("rnd valid", 32'(valid_o), 32'(m_valid));
      chk("rnd overflow", 32'(ovf_o), 32'(m_ovf));
      chk("rnd len_err", 32'(lerr_o), 32'(m_lerr));
      if (m_valid)
        chk("rnd packet", {5'b0, id_o, dnr_o, len_o, data_o},
            {5'b0, m_pkt.id, m_pkt.dnr, m_pkt.len, m_pkt.data});
      yumi = 1'($urandom);
      tms  = (q.size() > 0) && ($urandom_range(3, 0) != 0);
      load_evt = 1'b0;
      if (tms) begin
        e   = q.pop_front();
        tdi = e.b;
        if (e.errmark) m_lerr = 1'b1;
        load_evt = e.last;
      end else begin
        tdi = 1'($urandom);
      end
      if (load_evt) begin
        if (!m_valid || yumi) begin
          m_valid = 1'b1;
          m_pkt   = e;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && yumi) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("random stream drained", 32'(q.size()), 32'd0);
    tms = 1'b0; yumi = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
